// File: rtl/helios_frame_controller.sv
// Host-side controller for the decoder link. It sends START once, streams framed and padded
// syndrome bytes, and collects a fixed-length result message, with a response timeout.
module helios_frame_controller #(
    parameter int unsigned PU_PER_ROUND   = 6,
    parameter int unsigned ROUNDS         = 3,
    parameter int unsigned RESP_BYTES     = 3,
    parameter logic [7:0]  START_MSG      = 8'h01,
    parameter logic [7:0]  HEADER_MSG     = 8'h02,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned COUNT_WIDTH    = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [PU_PER_ROUND*ROUNDS-1:0] syn_data,
    input  logic                           syn_valid,
    output logic                           syn_ready,
    output logic [7:0]                     tx_data,
    output logic                           tx_valid,
    input  logic                           tx_ready,
    input  logic [7:0]                     rx_data,
    input  logic                           rx_valid,
    output logic                           rx_ready,
    output logic [7:0]                     res_iterations,
    output logic [15:0]                    res_cycles,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic                           busy,
    output logic                           timeout_err,
    output logic [COUNT_WIDTH-1:0]         frames_done
);

    localparam int unsigned SYN_W       = PU_PER_ROUND * ROUNDS;
    localparam int unsigned BPR         = (PU_PER_ROUND + 7) >> 3;
    localparam int unsigned FRAME_BYTES = BPR * ROUNDS;
    localparam int unsigned IDX_W       = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam int unsigned RX_W        = $clog2(RESP_BYTES);
    localparam int unsigned TMO_W       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_START, ST_IDLE, ST_HDR, ST_DATA, ST_WAIT_RESP, ST_RESP, ST_DELIVER
    } state_e;

    state_e                 state_q, state_d;
    logic [SYN_W-1:0]       shadow_q, shadow_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [RX_W-1:0]        rx_idx_q, rx_idx_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   tx_valid_q, tx_valid_d;
    logic                   syn_ready_q, syn_ready_d;
    logic                   rx_ready_q, rx_ready_d;
    logic [7:0]             res_iter_q, res_iter_d;
    logic [15:0]            res_cyc_q, res_cyc_d;
    logic                   res_valid_q, res_valid_d;
    logic                   busy_q, busy_d;
    logic                   tmo_err_q, tmo_err_d;
    logic [COUNT_WIDTH-1:0] frames_q, frames_d;

    // Shadow frame re-laid out as byte-aligned rounds, zero-padded above PU_PER_ROUND
    logic [FRAME_BYTES*8-1:0] frame_flat;

    for (genvar r = 0; r < ROUNDS; r++) begin : g_round
        for (genvar j = 0; j < BPR * 8; j++) begin : g_bit
            if (j < PU_PER_ROUND) begin : g_data
                assign frame_flat[r*BPR*8 + j] = shadow_q[r*PU_PER_ROUND + j];
            end else begin : g_pad
                assign frame_flat[r*BPR*8 + j] = 1'b0;
            end
        end
    end

    logic [IDX_W-1:0] idx_nxt;
    logic             tx_hs, rx_hs, syn_hs;

    assign idx_nxt = idx_q + IDX_W'(1);
    assign tx_hs   = tx_valid_q && tx_ready;
    assign rx_hs   = rx_valid && rx_ready_q;
    assign syn_hs  = syn_valid && syn_ready_q;

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        idx_d       = idx_q;
        rx_idx_d    = rx_idx_q;
        tmo_d       = tmo_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        syn_ready_d = syn_ready_q;
        rx_ready_d  = rx_ready_q;
        res_iter_d  = res_iter_q;
        res_cyc_d   = res_cyc_q;
        res_valid_d = res_valid_q;
        tmo_err_d   = tmo_err_q;
        frames_d    = frames_q;

        unique case (state_q)
            ST_START: begin
                if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = START_MSG;
                end else if (tx_ready) begin
                    tx_valid_d  = 1'b0;
                    syn_ready_d = 1'b1;
                    rx_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (syn_hs) begin
                    shadow_d    = syn_data;
                    tx_valid_d  = 1'b1;
                    tx_data_d   = HEADER_MSG;
                    syn_ready_d = 1'b0;
                    rx_ready_d  = 1'b0;
                    state_d     = ST_HDR;
                end
            end
            ST_HDR: begin
                if (tx_hs) begin
                    idx_d     = '0;
                    tx_data_d = frame_flat[7:0];
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tx_hs) begin
                    if (idx_q == IDX_W'(FRAME_BYTES - 1)) begin
                        tx_valid_d = 1'b0;
                        tmo_d      = '0;
                        rx_idx_d   = '0;
                        rx_ready_d = 1'b1;
                        state_d    = ST_WAIT_RESP;
                    end else begin
                        idx_d     = idx_nxt;
                        tx_data_d = frame_flat[{idx_nxt, 3'b000} +: 8];
                    end
                end
            end
            ST_WAIT_RESP, ST_RESP: begin
                if (rx_hs) begin
                    tmo_d = '0;
                    // Bytes past the first three are accepted and dropped
                    case (rx_idx_q)
                        RX_W'(0): res_iter_d       = rx_data;
                        RX_W'(1): res_cyc_d[15:8]  = rx_data;
                        RX_W'(2): res_cyc_d[7:0]   = rx_data;
                        default:  ;
                    endcase
                    if (rx_idx_q == RX_W'(RESP_BYTES - 1)) begin
                        res_valid_d = 1'b1;
                        rx_ready_d  = 1'b0;
                        state_d     = ST_DELIVER;
                    end else begin
                        rx_idx_d = rx_idx_q + RX_W'(1);
                        state_d  = ST_RESP;
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    tmo_err_d   = 1'b1;
                    syn_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_DELIVER: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    frames_d    = frames_q + COUNT_WIDTH'(1);
                    syn_ready_d = 1'b1;
                    rx_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_START;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_START;
            shadow_q    <= '0;
            idx_q       <= '0;
            rx_idx_q    <= '0;
            tmo_q       <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            syn_ready_q <= 1'b0;
            rx_ready_q  <= 1'b0;
            res_iter_q  <= '0;
            res_cyc_q   <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            tmo_err_q   <= 1'b0;
            frames_q    <= '0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            idx_q       <= idx_d;
            rx_idx_q    <= rx_idx_d;
            tmo_q       <= tmo_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            syn_ready_q <= syn_ready_d;
            rx_ready_q  <= rx_ready_d;
            res_iter_q  <= res_iter_d;
            res_cyc_q   <= res_cyc_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            tmo_err_q   <= tmo_err_d;
            frames_q    <= frames_d;
        end
    end

    assign syn_ready      = syn_ready_q;
    assign tx_data        = tx_data_q;
    assign tx_valid       = tx_valid_q;
    assign rx_ready       = rx_ready_q;
    assign res_iterations = res_iter_q;
    assign res_cycles     = res_cyc_q;
    assign res_valid      = res_valid_q;
    assign busy           = busy_q;
    assign timeout_err    = tmo_err_q;
    assign frames_done    = frames_q;

endmodule

// File: doc/helios_frame_controller.md
Name: helios_frame_controller

Overview:
- Synthesizable host-side controller between a parallel syndrome source and the byte-wide valid/ready decoder link.
- Sends a one-time START message, then for each syndrome frame: a HEADER byte followed by padded measurement bytes.
- Collects a fixed-length result message (iteration count, 16-bit cycle count) and presents it as one parallel result word.
- Extends the earlier fixed d=3 loading sequence with parametrised geometry, in-block padding, fixed-length response framing and a response timeout.

Parameters:
- PU_PER_ROUND, 6, syndrome bits per measurement round (CODE_DISTANCE_X*CODE_DISTANCE_Z).
- ROUNDS, 3, measurement rounds per frame.
- RESP_BYTES, 3, bytes per decoder result message; must be at least 3.
- START_MSG, 8'h01, start-decoding message byte.
- HEADER_MSG, 8'h02, measurement-data header byte.
- TIMEOUT_CYCLES, 65535, maximum idle cycles allowed while awaiting result bytes.
- COUNT_WIDTH, 16, width of frames_done.
- Derived: BPR = (PU_PER_ROUND+7)>>3 and FRAME_BYTES = BPR*ROUNDS.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- syn_data  in  PU_PER_ROUND*ROUNDS  packed unpadded syndrome; round r occupies bits [r*PU_PER_ROUND +: PU_PER_ROUND].
- syn_valid  in  1  frame offered.
- syn_ready  out  1  frame accepted when syn_valid && syn_ready.
- tx_data  out  8  byte to decoder input.
- tx_valid  out  1  tx byte valid.
- tx_ready  in  1  decoder accepts byte.
- rx_data  in  8  byte from decoder output.
- rx_valid  in  1  rx byte valid.
- rx_ready  out  1  controller accepts byte.
- res_iterations  out  8  result byte 0.
- res_cycles  out  16  {result byte 1, result byte 2}.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed.
- busy  out  1  high when not in IDLE.
- timeout_err  out  1  sticky timeout flag.
- frames_done  out  COUNT_WIDTH  completed frames; wraps modulo 2^COUNT_WIDTH.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high. Reset drives state to START and clears all outputs to 0, except tx_valid=1 and tx_data=START_MSG from the first clock edge after reset deasserts.
- All outputs are registered.
- tx_data must not change while tx_valid && !tx_ready; the same holds for res_* while res_valid && !res_ready.
- START: holds START_MSG until tx_ready, then -> IDLE. START is sent only once per reset.
- IDLE:
  - syn_ready=1 and rx_ready=1; stale rx bytes are dropped.
  - On syn handshake at edge T: latch the frame into a shadow register; tx_valid=1 with HEADER_MSG from T+1; -> HDR.
- HDR: on tx_ready -> DATA with byte index 0, and tx_data = frame byte 0 on the next cycle.
- DATA:
  - Frame byte n = r*BPR + b carries shadow bits [r*PU_PER_ROUND + 8b +: 8] restricted to that round. Bits at positions >= PU_PER_ROUND within a round are transmitted as 0.
  - Advance on tx_ready; after byte FRAME_BYTES-1 is accepted: tx_valid=0, clear timeout counter, -> WAIT_RESP.
- WAIT_RESP and RESP:
  - rx_ready=1 throughout.
  - The n-th accepted rx byte is stored as follows: n=0 to res_iterations, n=1 to res_cycles[15:8], n=2 to res_cycles[7:0]. Bytes 3..RESP_BYTES-1 are accepted and discarded.
  - After byte RESP_BYTES-1: res_valid=1, rx_ready=0, -> DELIVER.
- Timeout:
  - The counter increments each cycle with no rx handshake and resets on any handshake.
  - When the counter reaches TIMEOUT_CYCLES-1: set timeout_err (sticky until reset), res_valid stays 0, frames_done is unchanged, -> IDLE.
- DELIVER: on res_ready, res_valid=0, frames_done += 1 in the same edge, -> IDLE. A new syn handshake is possible no earlier than the following cycle.
- Frames are strictly serialized: syn_ready=0 in every state except IDLE.
- Reset mid-frame aborts all traffic: the partial frame is not resumed and START is re-sent.
- busy=0 only in IDLE.

Test Plan:
- Reset release, tx_ready=1 -> tx shows 01 once; syn_ready rises the cycle after the START handshake.
- Defaults, syn_data=18'b000001_111111_101010, tx_ready=1 -> tx bytes 02,2A,3F,01 on consecutive cycles. Decoder returns 05,01,2C -> res_iterations=5, res_cycles=16'h012C, res_valid=1; after res_ready, frames_done=1.
- Same frame with tx_ready toggled 1,0,0,1,... -> identical byte order, each byte stable while stalled, no byte duplicated or dropped.
- PU_PER_ROUND=12, ROUNDS=5 (d=5), all syn bits 1 -> 10 data bytes alternating FF,0F.
- RESP_BYTES=5 with responses 07,00,40,AA,BB -> res_iterations=7, res_cycles=16'h0040; AA and BB are discarded; returns to IDLE.
- TIMEOUT_CYCLES=16, no rx bytes after frame -> timeout_err=1 after 16 cycles, res_valid=0, frames_done unchanged. A reset asserted mid-DATA instead -> next tx byte after release is 01.
